// File: rtl/full_adder_xcheck.sv
// full_adder_xcheck: 1-bit full adder built twice (dataflow and procedural),
// with registered results, a sticky cross-check flag, input-combination
// coverage tracking and a saturating count of accepted vectors.
`timescale 1ns/1ps
module full_adder_xcheck #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             x,
    input  logic             y,
    input  logic             cin,
    input  logic             err_clr,
    output logic             sum_cont,
    output logic             cout_cont,
    output logic             sum_comb,
    output logic             cout_comb,
    output logic             out_valid,
    output logic             mismatch,
    output logic [7:0]       cov_mask,
    output logic             cov_full,
    output logic [CNT_W-1:0] vec_cnt
);

    // Saturating increment: holds at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}})
            return v;
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Dataflow path: plain continuous assignments.
    logic sum_df;
    logic cout_df;
    assign sum_df  = x ^ y ^ cin;
    assign cout_df = (x & y) | (x & cin) | (y & cin);

    // Procedural path: truth-table lookup, deliberately independent of the XOR/majority gates above.
    logic sum_proc;
    logic cout_proc;
    always_comb begin
        sum_proc  = 1'b0;
        cout_proc = 1'b0;
        case ({x, y, cin})
            3'b000: begin cout_proc = 1'b0; sum_proc = 1'b0; end
            3'b001: begin cout_proc = 1'b0; sum_proc = 1'b1; end
            3'b010: begin cout_proc = 1'b0; sum_proc = 1'b1; end
            3'b011: begin cout_proc = 1'b1; sum_proc = 1'b0; end
            3'b100: begin cout_proc = 1'b0; sum_proc = 1'b1; end
            3'b101: begin cout_proc = 1'b1; sum_proc = 1'b0; end
            3'b110: begin cout_proc = 1'b1; sum_proc = 1'b0; end
            3'b111: begin cout_proc = 1'b1; sum_proc = 1'b1; end
            default: begin cout_proc = 1'bx; sum_proc = 1'bx; end
        endcase
    end

    logic             sum_cont_q,  sum_cont_d;
    logic             cout_cont_q, cout_cont_d;
    logic             sum_comb_q,  sum_comb_d;
    logic             cout_comb_q, cout_comb_d;
    logic             out_valid_q, out_valid_d;
    logic             mismatch_q,  mismatch_d;
    logic [7:0]       cov_mask_q,  cov_mask_d;
    logic [CNT_W-1:0] vec_cnt_q,   vec_cnt_d;
    logic [7:0]       cov_mask_set;

    // Next-state: results load on accept; err_clr beats the accept for the status registers only.
    always_comb begin
        sum_cont_d   = sum_cont_q;
        cout_cont_d  = cout_cont_q;
        sum_comb_d   = sum_comb_q;
        cout_comb_d  = cout_comb_q;
        out_valid_d  = in_valid;
        mismatch_d   = mismatch_q;
        cov_mask_d   = cov_mask_q;
        vec_cnt_d    = vec_cnt_q;
        cov_mask_set = cov_mask_q;
        cov_mask_set[{x, y, cin}] = 1'b1;
        if (in_valid) begin
            sum_cont_d  = sum_df;
            cout_cont_d = cout_df;
            sum_comb_d  = sum_proc;
            cout_comb_d = cout_proc;
            cov_mask_d  = cov_mask_set;
            vec_cnt_d   = sat_inc(vec_cnt_q);
            if ({cout_df, sum_df} != {cout_proc, sum_proc})
                mismatch_d = 1'b1;
        end
        if (err_clr) begin
            mismatch_d = 1'b0;
            cov_mask_d = 8'h00;
            vec_cnt_d  = '0;
        end
    end

    // State registers; asynchronous reset also drops any vector in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_cont_q  <= 1'b0;
            cout_cont_q <= 1'b0;
            sum_comb_q  <= 1'b0;
            cout_comb_q <= 1'b0;
            out_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
            cov_mask_q  <= 8'h00;
            vec_cnt_q   <= '0;
        end else begin
            sum_cont_q  <= sum_cont_d;
            cout_cont_q <= cout_cont_d;
            sum_comb_q  <= sum_comb_d;
            cout_comb_q <= cout_comb_d;
            out_valid_q <= out_valid_d;
            mismatch_q  <= mismatch_d;
            cov_mask_q  <= cov_mask_d;
            vec_cnt_q   <= vec_cnt_d;
        end
    end

    assign sum_cont  = sum_cont_q;
    assign cout_cont = cout_cont_q;
    assign sum_comb  = sum_comb_q;
    assign cout_comb = cout_comb_q;
    assign out_valid = out_valid_q;
    assign mismatch  = mismatch_q;
    assign cov_mask  = cov_mask_q;
    assign cov_full  = (cov_mask_q == 8'hFF);
    assign vec_cnt   = vec_cnt_q;

endmodule

// File: tb/tb_full_adder_xcheck.sv
// Directed bench for full_adder_xcheck: reset, exhaustive sweep, hold,
// injected path disagreement, and counter saturation with clear.
`timescale 1ns/1ps
module tb_full_adder_xcheck;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       x, y, cin;
    logic       err_clr;
    logic       sum_cont, cout_cont, sum_comb, cout_comb;
    logic       out_valid, mismatch, cov_full;
    logic [7:0] cov_mask;
    logic [7:0] vec_cnt;

    int errors = 0;
    int checks = 0;

    full_adder_xcheck #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .y(y), .cin(cin),
        .err_clr(err_clr), .sum_cont(sum_cont), .cout_cont(cout_cont),
        .sum_comb(sum_comb), .cout_comb(cout_comb), .out_valid(out_valid),
        .mismatch(mismatch), .cov_mask(cov_mask), .cov_full(cov_full), .vec_cnt(vec_cnt)
    );

    always #5 clk = ~clk;

    // Hand-written truth table, index {x,y,cin} -> {cout,sum}.
    logic [1:0] tt [8];
    initial begin
        tt[0] = 2'b00; tt[1] = 2'b01; tt[2] = 2'b01; tt[3] = 2'b10;
        tt[4] = 2'b01; tt[5] = 2'b10; tt[6] = 2'b10; tt[7] = 2'b11;
    end

    // Present one cycle of stimulus, take the edge, then settle 1ns past it.
    task automatic drive(input logic [2:0] v, input logic vld, input logic clr);
        {x, y, cin} = v;
        in_valid = vld;
        err_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; {x, y, cin} = 3'b000; err_clr = 1'b0;
        #12;
        rst_n = 1'b1;
        drive(3'b111, 1'b1, 1'b0);   // now t=16
        #2;                          // t=18, mid-cycle, inputs still 111 valid
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sum_cont, cout_cont, sum_comb, cout_comb, out_valid, mismatch, cov_full} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outs: got %b required 0000000",
                     {sum_cont, cout_cont, sum_comb, cout_comb, out_valid, mismatch, cov_full});
        end
        checks++;
        if (cov_mask !== 8'h00) begin errors++; $display("FAIL reset_cov_mask: got %h required 00", cov_mask); end
        checks++;
        if (vec_cnt !== 8'd0) begin errors++; $display("FAIL reset_vec_cnt: got %0d required 0", vec_cnt); end
        #8;                          // t=27, past the edge at 25 which was held in reset
        rst_n = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_stale_valid: got %b required 0", out_valid); end
        drive(3'b111, 1'b1, 1'b0);
        checks++;
        if ({cout_cont, sum_cont, cout_comb, sum_comb, out_valid} !== 5'b11111) begin
            errors++;
            $display("FAIL reset_first_vec: got %b required 11111",
                     {cout_cont, sum_cont, cout_comb, sum_comb, out_valid});
        end
        checks++;
        if (vec_cnt !== 8'd1) begin errors++; $display("FAIL reset_first_cnt: got %0d required 1", vec_cnt); end
    endtask

    task automatic test_sweep;
        drive(3'b000, 1'b0, 1'b1);   // clear status left by the reset test
        checks++;
        if (vec_cnt !== 8'd0 || cov_mask !== 8'h00) begin
            errors++; $display("FAIL sweep_preclear: got cnt=%0d mask=%h required 0/00", vec_cnt, cov_mask);
        end
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = i[2:0];
            drive(v, 1'b1, 1'b0);
            checks++;
            if ({cout_cont, sum_cont} !== tt[i] || {cout_comb, sum_comb} !== tt[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL sweep_%0d: got cont=%b comb=%b vld=%b required %b vld=1",
                         i, {cout_cont, sum_cont}, {cout_comb, sum_comb}, out_valid, tt[i]);
            end
            checks++;
            if (mismatch !== 1'b0) begin errors++; $display("FAIL sweep_mismatch_%0d: got %b required 0", i, mismatch); end
        end
        checks++;
        if (cov_mask !== 8'hFF || cov_full !== 1'b1) begin
            errors++; $display("FAIL sweep_cov: got mask=%h full=%b required FF/1", cov_mask, cov_full);
        end
        checks++;
        if (vec_cnt !== 8'd8) begin errors++; $display("FAIL sweep_cnt: got %0d required 8", vec_cnt); end
    endtask

    task automatic test_hold;
        drive(3'b110, 1'b1, 1'b0);
        checks++;
        if ({cout_cont, sum_cont, cout_comb, sum_comb} !== 4'b1010) begin
            errors++; $display("FAIL hold_load: got %b required 1010", {cout_cont, sum_cont, cout_comb, sum_comb});
        end
        for (int i = 0; i < 3; i++) begin
            drive(3'b001, 1'b0, 1'b0);
            checks++;
            if ({cout_cont, sum_cont, cout_comb, sum_comb, out_valid} !== 5'b10100 || vec_cnt !== 8'd9) begin
                errors++;
                $display("FAIL hold_%0d: got res=%b cnt=%0d required 10100 cnt=9",
                         i, {cout_cont, sum_cont, cout_comb, sum_comb, out_valid}, vec_cnt);
            end
        end
    endtask

    task automatic test_mismatch;
        {x, y, cin} = 3'b101;
        force dut.sum_proc = 1'b1;   // true sum for 101 is 0
        drive(3'b101, 1'b1, 1'b0);
        release dut.sum_proc;
        checks++;
        if (mismatch !== 1'b1) begin errors++; $display("FAIL mm_set: got %b required 1", mismatch); end
        checks++;
        if (sum_cont !== 1'b0 || sum_comb !== 1'b1) begin
            errors++; $display("FAIL mm_paths: got cont=%b comb=%b required 0/1", sum_cont, sum_comb);
        end
        drive(3'b000, 1'b1, 1'b0);
        drive(3'b011, 1'b1, 1'b0);
        checks++;
        if (mismatch !== 1'b1) begin errors++; $display("FAIL mm_sticky: got %b required 1", mismatch); end
        checks++;
        if ({cout_cont, sum_cont, cout_comb, sum_comb} !== 4'b1010) begin
            errors++; $display("FAIL mm_clean_vec: got %b required 1010", {cout_cont, sum_cont, cout_comb, sum_comb});
        end
        checks++;
        if (vec_cnt !== 8'd12) begin errors++; $display("FAIL mm_cnt: got %0d required 12", vec_cnt); end
        drive(3'b000, 1'b0, 1'b1);
        checks++;
        if (mismatch !== 1'b0 || vec_cnt !== 8'd0 || cov_mask !== 8'h00) begin
            errors++;
            $display("FAIL mm_clear: got mm=%b cnt=%0d mask=%h required 0/0/00", mismatch, vec_cnt, cov_mask);
        end
    endtask

    task automatic test_saturation;
        for (int i = 1; i <= 300; i++) begin
            logic [8:0] iv;
            iv = i[8:0];
            drive(iv[2:0], 1'b1, 1'b0);
            if (i == 254 || i == 255) begin
                checks++;
                if (vec_cnt !== iv[7:0]) begin
                    errors++; $display("FAIL sat_cnt_%0d: got %0d required %0d", i, vec_cnt, i);
                end
            end
        end
        checks++;
        if (vec_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d required 255", vec_cnt); end
        checks++;
        if (cov_full !== 1'b1 || mismatch !== 1'b0) begin
            errors++; $display("FAIL sat_status: got full=%b mm=%b required 1/0", cov_full, mismatch);
        end
        drive(3'b011, 1'b1, 1'b1);   // clear and accept on the same edge
        checks++;
        if (vec_cnt !== 8'd0 || cov_mask !== 8'h00 || cov_full !== 1'b0) begin
            errors++;
            $display("FAIL clr_prio: got cnt=%0d mask=%h full=%b required 0/00/0", vec_cnt, cov_mask, cov_full);
        end
        checks++;
        if ({cout_cont, sum_cont, cout_comb, sum_comb, out_valid} !== 5'b10101) begin
            errors++;
            $display("FAIL clr_results: got %b required 10101", {cout_cont, sum_cont, cout_comb, sum_comb, out_valid});
        end
        drive(3'b100, 1'b1, 1'b0);
        checks++;
        if (vec_cnt !== 8'd1 || cov_mask !== 8'h10) begin
            errors++; $display("FAIL post_clr: got cnt=%0d mask=%h required 1/10", vec_cnt, cov_mask);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_hold();
        test_mismatch();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/full_adder_xcheck.md
# full_adder_xcheck

Dual-implementation 1-bit full adder with registered outputs and a built-in cross-check. It carries two independent full-adder datapaths: a dataflow (continuous-assignment) version and a procedural (combinational always-block) version. Both are fed the same operands, and the block flags any disagreement between them. It also records which of the 8 input combinations have been applied, for exhaustive-coverage sign-off. It sits as a leaf arithmetic cell with self-check, between a stimulus/operand source and any downstream consumer or status register.

## Interface
- CNT_W, default 8: width of the evaluated-vector counter.
- clk  input  1  rising-edge clock; the single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid this cycle.
- x  input  1  addend A.
- y  input  1  addend B.
- cin  input  1  carry in.
- err_clr  input  1  synchronous clear of mismatch, cov_mask and vec_cnt.
- sum_cont  output  1  registered sum, dataflow path.
- cout_cont  output  1  registered carry out, dataflow path.
- sum_comb  output  1  registered sum, procedural path.
- cout_comb  output  1  registered carry out, procedural path.
- out_valid  output  1  registered copy of in_valid.
- mismatch  output  1  sticky flag: the two paths disagreed on an accepted vector.
- cov_mask  output  8  bit {x,y,cin} set once that combination has been accepted.
- cov_full  output  1  asserted when cov_mask == 8'hFF.
- vec_cnt  output  CNT_W  count of accepted vectors; saturates at all-ones.

## Operation
- Dataflow path:
  - sum = x ^ y ^ cin
  - cout = (x & y) | (x & cin) | (y & cin)
- Procedural path:
  - Computes the same function through a combinational always block with a case statement on {x,y,cin}.
  - Shares no logic with the dataflow path.
- Truth table, {x,y,cin} -> {cout,sum}: 000->00, 001->01, 010->01, 011->10, 100->01, 101->10, 110->10, 111->11.
- Accepted vector: in_valid=1 at a rising clk edge.
- On an accepted vector, in one edge:
  - Both result pairs are registered.
  - out_valid goes to 1.
  - cov_mask[{x,y,cin}] is set.
  - vec_cnt increments, unless it is saturated.
  - mismatch is set if {cout_cont,sum_cont} != {cout_comb,sum_comb}, compared pre-register on the same operands.
- When in_valid=0:
  - The result registers hold their previous values.
  - out_valid goes to 0.
  - cov_mask, vec_cnt and mismatch are unchanged.
- err_clr=1 at an edge:
  - Clears mismatch, cov_mask and vec_cnt.
  - Takes priority over a simultaneous accepted vector; that vector's results are still registered.
- X/Z on an operand while in_valid=1: the vector is still accepted. Behaviour under X is not guaranteed and is not tested.

## Timing
- Latency: exactly 1 clk from the accepting edge to sum_*, cout_* and out_valid.
- Throughput: 1 vector per clock; no backpressure.
- cov_full is combinational from cov_mask.
- Reset (rst_n=0, asynchronous, immediate):
  - sum_cont, cout_cont, sum_comb, cout_comb, out_valid and mismatch go to 0.
  - cov_mask goes to 8'h00; cov_full goes to 0; vec_cnt goes to 0.
- Reset mid-stream: an in-flight vector is discarded, with no out_valid pulse after reset.
- The first edge after rst_n deasserts accepts normally.
- vec_cnt saturation: at all-ones (255 with the default CNT_W) further vectors leave it unchanged. cov_mask and mismatch still update.

## Test plan
- Reset check:
  - Drive rst_n=0 mid-cycle with x=y=cin=1 and in_valid=1.
  - All outputs go to 0 immediately, without waiting for a clk edge.
  - After release, the first vector 111 gives {cout,sum}=11 on both paths one cycle later.
- Exhaustive sweep:
  - Apply {x,y,cin}=000..111, one per cycle.
  - Each output pair matches the truth table one cycle later.
  - Both paths stay identical and mismatch stays 0.
  - After the sweep: cov_mask=8'hFF, cov_full=1, vec_cnt=8.
- Hold:
  - Apply 110, then drop in_valid for 3 cycles.
  - Outputs hold {cout,sum}=10 and out_valid=0.
  - vec_cnt is unchanged.
- Mismatch injection:
  - Force the procedural sum to invert for vector 101.
  - mismatch=1 one cycle later and stays 1 through further clean vectors.
  - err_clr clears it to 0.
- Saturation:
  - Apply 300 accepted vectors.
  - vec_cnt stops at 255.
  - A simultaneous err_clr with a vector gives vec_cnt=0 and cov_mask=0, while the results are still registered.
